// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory-stage access controller.
// Size codes, FSM state constants, byte-lane mask and alignment check.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RD_WAIT = 2'd1;
    localparam state_t ST_IO_WAIT = 2'd2;

    // Reserved size code behaves as a full word everywhere.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << off;
            SZ_HALF: mask = 4'b0011 << {off[1], 1'b0};
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data BRAM and memory-mapped IO bus between the access controller and its targets.
// master = controller side, slave = memory / IO side.
interface mem_access_ctrl_if #(
    parameter int RAM_AW = 12
);
    logic [RAM_AW-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [31:0]       io_addr;
    logic [31:0]       io_wdata;
    logic              io_re;
    logic              io_we;
    logic [31:0]       io_rdata;
    logic              io_ready;

    modport master (
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output io_addr, io_wdata, io_re, io_we,
        input  io_rdata, io_ready
    );

    modport slave (
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  io_addr, io_wdata, io_re, io_we,
        output io_rdata, io_ready
    );
endinterface

// File: rtl/mem_load_align.sv
// Load extraction: picks the byte/half lane out of a 32-bit word and zero- or sign-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: BRAM stores/loads with lane steering, IO requests with
// timeout, misalignment detection, and pipeline stall generation. rst_n is active-high.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int RAM_AW     = 12,
    parameter int IO_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic               IoRead_i,
    input  logic               IoWrite_i,
    input  logic [1:0]         ByteOrWord_i,
    input  logic               LoadUnsigned_i,
    input  logic [31:0]        ALUResult_i,
    input  logic [31:0]        rdata2_i,
    mem_access_ctrl_if.master  bus,
    output logic [31:0]        rdata_o,
    output logic               valid_o,
    output logic               stall_o,
    output logic               misalign_o,
    output logic               err_o
);

    localparam int CW = $clog2(IO_TIMEOUT + 1);

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_uns;

    logic        w_idle;
    logic        w_io_req;
    logic        w_mem_rd;
    logic        w_mem_wr;
    logic        w_any_req;
    logic        w_is_load;
    logic        w_misalign;
    logic        w_timeout;
    logic [31:0] w_align_word;
    logic [31:0] w_ext;

    // IO outranks Mem, and Read outranks Write within each class.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_io_req   = IoRead_i | IoWrite_i;
    assign w_mem_rd   = ~w_io_req & MemRead_i;
    assign w_mem_wr   = ~w_io_req & ~MemRead_i & MemWrite_i;
    assign w_any_req  = w_io_req | MemRead_i | MemWrite_i;
    assign w_is_load  = IoRead_i | w_mem_rd;
    assign w_misalign = w_any_req & is_misaligned(ByteOrWord_i, ALUResult_i[1:0]);
    assign w_timeout  = (r_cnt == CW'(IO_TIMEOUT - 1));

    assign bus.ram_addr = ALUResult_i[RAM_AW+1:2];

    always_comb begin
        bus.ram_we = '0;
        if (w_idle && w_mem_wr && !w_misalign) begin
            bus.ram_we = lane_mask(ByteOrWord_i, ALUResult_i[1:0]);
        end
    end

    always_comb begin
        case (ByteOrWord_i)
            SZ_BYTE: bus.ram_wdata = {4{rdata2_i[7:0]}};
            SZ_HALF: bus.ram_wdata = {2{rdata2_i[15:0]}};
            default: bus.ram_wdata = rdata2_i;
        endcase
    end

    // Stall covers the request cycle and every IO_WAIT cycle that neither completes nor aborts.
    always_comb begin
        case (r_state)
            ST_IDLE:    stall_o = ~w_misalign & (w_io_req | w_mem_rd);
            ST_IO_WAIT: stall_o = ~bus.io_ready & ~w_timeout;
            default:    stall_o = 1'b0;
        endcase
    end

    assign w_align_word = (r_state == ST_IO_WAIT) ? bus.io_rdata : bus.ram_rdata;

    mem_load_align u_align (
        .i_word     (w_align_word),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_off       <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            rdata_o     <= '0;
            valid_o     <= 1'b0;
            misalign_o  <= 1'b0;
            err_o       <= 1'b0;
            bus.io_addr  <= '0;
            bus.io_wdata <= '0;
            bus.io_re    <= 1'b0;
            bus.io_we    <= 1'b0;
        end else begin
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
            err_o      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_misalign) begin
                        misalign_o <= 1'b1;
                        if (w_is_load) begin
                            rdata_o <= '0;
                            valid_o <= 1'b1;
                        end
                    end else if (w_io_req) begin
                        bus.io_addr  <= ALUResult_i;
                        bus.io_wdata <= rdata2_i;
                        bus.io_re    <= IoRead_i;
                        bus.io_we    <= ~IoRead_i;
                        r_off        <= ALUResult_i[1:0];
                        r_size       <= ByteOrWord_i;
                        r_uns        <= LoadUnsigned_i;
                        r_cnt        <= '0;
                        r_state      <= ST_IO_WAIT;
                    end else if (w_mem_rd) begin
                        r_off   <= ALUResult_i[1:0];
                        r_size  <= ByteOrWord_i;
                        r_uns   <= LoadUnsigned_i;
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    rdata_o <= w_ext;
                    valid_o <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_IO_WAIT: begin
                    if (bus.io_ready) begin
                        if (bus.io_re) begin
                            rdata_o <= w_ext;
                            valid_o <= 1'b1;
                        end
                        bus.io_re <= 1'b0;
                        bus.io_we <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_timeout) begin
                        if (bus.io_re) begin
                            rdata_o <= '0;
                            valid_o <= 1'b1;
                        end
                        err_o     <= 1'b1;
                        bus.io_re <= 1'b0;
                        bus.io_we <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-array memory model and a behavioural IO device.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int RAM_AW     = 12;
    localparam int IO_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_i, MemWrite_i, IoRead_i, IoWrite_i;
    logic [1:0]  ByteOrWord_i;
    logic        LoadUnsigned_i;
    logic [31:0] ALUResult_i, rdata2_i;
    logic [31:0] rdata_o;
    logic        valid_o, stall_o, misalign_o, err_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] bram [4096];
    logic [7:0]  ref_mem [64];

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.RAM_AW(RAM_AW)) bus ();

    mem_access_ctrl #(.RAM_AW(RAM_AW), .IO_TIMEOUT(IO_TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemRead_i      (MemRead_i),
        .MemWrite_i     (MemWrite_i),
        .IoRead_i       (IoRead_i),
        .IoWrite_i      (IoWrite_i),
        .ByteOrWord_i   (ByteOrWord_i),
        .LoadUnsigned_i (LoadUnsigned_i),
        .ALUResult_i    (ALUResult_i),
        .rdata2_i       (rdata2_i),
        .bus            (bus),
        .rdata_o        (rdata_o),
        .valid_o        (valid_o),
        .stall_o        (stall_o),
        .misalign_o     (misalign_o),
        .err_o          (err_o)
    );

    // Synchronous BRAM, read-first, one cycle read latency.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.ram_we[b]) bram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
        end
        bus.ram_rdata <= bram[bus.ram_addr];
    end

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic misal(input logic [31:0] a, input logic [1:0] sz);
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input int n, input logic uns);
        logic [31:0] mask;
        if (n >= 4) return raw;
        mask = (32'd1 << (8 * n)) - 32'd1;
        if (!uns && raw[8*n-1]) return (raw & mask) | ~mask;
        return raw & mask;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] raw;
        int base;
        raw  = '0;
        base = int'(a[5:0]);
        for (int i = 0; i < nbytes(sz); i++) raw = raw | ({24'd0, ref_mem[base+i]} << (8 * i));
        return extend(raw, nbytes(sz), uns);
    endfunction

    function automatic logic [31:0] io_ext(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
        return extend(w >> (8 * int'(a[1:0])), nbytes(sz), uns);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        IoRead_i   = 1'b0;
        IoWrite_i  = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            output logic [3:0] got_we);
        logic        mis;
        int          n;
        logic [3:0]  ewe;
        logic [31:0] ewd;
        n   = nbytes(sz);
        mis = misal(a, sz);
        ewe = mis ? 4'b0000 : 4'(((1 << n) - 1) << int'(a[1:0]));
        ewd = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
        clear_in();
        MemWrite_i = 1'b1; ByteOrWord_i = sz; ALUResult_i = a; rdata2_i = d;
        #1;
        got_we = bus.ram_we;
        n_vec++; if (bus.ram_we !== ewe) begin n_err++; $display("FAIL st_we a=%h sz=%0d got %b exp %b", a, sz, bus.ram_we, ewe); end
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL st_stall a=%h got %b exp 0", a, stall_o); end
        if (!mis) begin
            n_vec++; if (bus.ram_wdata !== ewd) begin n_err++; $display("FAIL st_wdata a=%h got %h exp %h", a, bus.ram_wdata, ewd); end
            n_vec++; if (bus.ram_addr !== a[13:2]) begin n_err++; $display("FAIL st_addr a=%h got %h exp %h", a, bus.ram_addr, a[13:2]); end
        end
        tick();
        if (!mis) for (int i = 0; i < n; i++) ref_mem[int'(a[5:0])+i] = d[8*i +: 8];
        clear_in();
        n_vec++; if (misalign_o !== mis) begin n_err++; $display("FAIL st_misalign a=%h got %b exp %b", a, misalign_o, mis); end
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL st_valid a=%h got %b exp 0", a, valid_o); end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                           input logic wr_too, output logic [31:0] got);
        logic        mis;
        logic [31:0] exp;
        mis = misal(a, sz);
        clear_in();
        MemRead_i = 1'b1; MemWrite_i = wr_too; ByteOrWord_i = sz; ALUResult_i = a;
        LoadUnsigned_i = uns; rdata2_i = $urandom;
        #1;
        n_vec++; if (stall_o !== ~mis) begin n_err++; $display("FAIL ld_stall a=%h got %b exp %b", a, stall_o, ~mis); end
        n_vec++; if (bus.ram_we !== 4'b0000) begin n_err++; $display("FAIL ld_we a=%h got %b exp 0000", a, bus.ram_we); end
        tick();
        if (mis) begin
            clear_in();
            n_vec++; if (misalign_o !== 1'b1) begin n_err++; $display("FAIL ld_misalign a=%h got %b exp 1", a, misalign_o); end
            n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL ld_mis_valid a=%h got %b exp 1", a, valid_o); end
            n_vec++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL ld_mis_data a=%h got %h exp 0", a, rdata_o); end
            got = rdata_o;
        end else begin
            n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL ld_early_valid a=%h got %b exp 0", a, valid_o); end
            MemRead_i = 1'b0; MemWrite_i = 1'b1; ByteOrWord_i = SZ_WORD;
            ALUResult_i = a & ~32'd3; rdata2_i = $urandom;
            #1;
            n_vec++; if (bus.ram_we !== 4'b0000) begin n_err++; $display("FAIL ld_wait_we a=%h got %b exp 0000", a, bus.ram_we); end
            n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL ld_wait_stall a=%h got %b exp 0", a, stall_o); end
            tick();
            clear_in();
            exp = ref_load(a, sz, uns);
            n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL ld_valid a=%h got %b exp 1", a, valid_o); end
            n_vec++; if (rdata_o !== exp) begin n_err++; $display("FAIL ld_data a=%h sz=%0d u=%b got %h exp %h", a, sz, uns, rdata_o, exp); end
            n_vec++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL ld_misalign a=%h got %b exp 0", a, misalign_o); end
            got = rdata_o;
        end
        tick();
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL ld_pulse a=%h got %b exp 0", a, valid_o); end
    endtask

    // delay = IO_WAIT cycle index carrying io_ready (1 = first), 0 = device never answers.
    task automatic io_access(input logic rd, input logic [31:0] a, input logic [1:0] sz, input logic uns,
                             input logic [31:0] wd, input int delay, input logic [31:0] rword,
                             output logic [31:0] got);
        int          k, stalls, exp_stalls;
        logic        held_ok, done, exp_to;
        logic [31:0] exp;
        clear_in();
        IoRead_i  = rd;
        IoWrite_i = rd ? 1'($urandom_range(0, 1)) : 1'b1;
        MemRead_i = 1'($urandom_range(0, 1));
        ByteOrWord_i = sz; ALUResult_i = a; rdata2_i = wd; LoadUnsigned_i = uns;
        #1;
        n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL io_req_stall a=%h got %b exp 1", a, stall_o); end
        tick();
        n_vec++; if ({bus.io_re, bus.io_we} !== {rd, ~rd}) begin n_err++; $display("FAIL io_strobe got %b%b exp %b%b", bus.io_re, bus.io_we, rd, ~rd); end
        n_vec++; if (bus.io_addr !== a) begin n_err++; $display("FAIL io_addr got %h exp %h", bus.io_addr, a); end
        if (!rd) begin
            n_vec++; if (bus.io_wdata !== wd) begin n_err++; $display("FAIL io_wdata got %h exp %h", bus.io_wdata, wd); end
        end
        stalls = 1; held_ok = 1'b1; done = 1'b0; k = 1;
        while (!done) begin
            if (k == delay) begin
                bus.io_ready = 1'b1; bus.io_rdata = rword;
            end else begin
                bus.io_rdata = $urandom;
            end
            #1;
            if (stall_o === 1'b1) stalls++;
            if (bus.io_re !== rd || bus.io_we !== ~rd) held_ok = 1'b0;
            done = (k == delay) || (k >= IO_TIMEOUT);
            tick();
            bus.io_ready = 1'b0;
            k++;
        end
        clear_in();
        exp_to     = (delay == 0);
        exp_stalls = exp_to ? IO_TIMEOUT : delay;
        n_vec++; if (stalls != exp_stalls) begin n_err++; $display("FAIL io_stall_cycles got %0d exp %0d", stalls, exp_stalls); end
        n_vec++; if (!held_ok) begin n_err++; $display("FAIL io_hold got unstable exp steady strobes"); end
        n_vec++; if (valid_o !== rd) begin n_err++; $display("FAIL io_valid got %b exp %b", valid_o, rd); end
        n_vec++; if (err_o !== exp_to) begin n_err++; $display("FAIL io_err got %b exp %b", err_o, exp_to); end
        if (rd) begin
            exp = exp_to ? 32'h0 : io_ext(rword, a, sz, uns);
            n_vec++; if (rdata_o !== exp) begin n_err++; $display("FAIL io_rdata a=%h sz=%0d got %h exp %h", a, sz, rdata_o, exp); end
        end
        n_vec++; if ({bus.io_re, bus.io_we} !== 2'b00) begin n_err++; $display("FAIL io_drop got %b%b exp 00", bus.io_re, bus.io_we); end
        got = rdata_o;
        tick();
        n_vec++; if ({valid_o, err_o} !== 2'b00) begin n_err++; $display("FAIL io_pulse got %b%b exp 00", valid_o, err_o); end
    endtask

    task automatic test_reset();
        clear_in();
        ByteOrWord_i = 2'b00; LoadUnsigned_i = 1'b0; ALUResult_i = '0; rdata2_i = '0;
        bus.io_ready = 1'b0; bus.io_rdata = '0;
        rst_n = 1'b1;
        repeat (3) tick();
        n_vec++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h exp 0", rdata_o); end
        n_vec++; if ({valid_o, stall_o, misalign_o, err_o} !== 4'b0) begin n_err++; $display("FAIL rst_flags got %b exp 0000", {valid_o, stall_o, misalign_o, err_o}); end
        n_vec++; if ({bus.io_re, bus.io_we, bus.ram_we} !== 6'b0) begin n_err++; $display("FAIL rst_strobes got %b exp 0", {bus.io_re, bus.io_we, bus.ram_we}); end
        n_vec++; if ({bus.io_addr, bus.io_wdata} !== 64'h0) begin n_err++; $display("FAIL rst_io_bus got %h exp 0", {bus.io_addr, bus.io_wdata}); end
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [3:0] gw;
        for (int w = 0; w < 16; w++) do_store(32'h4000_0000 | (w << 2), $urandom, SZ_WORD, gw);
    endtask

    task automatic test_known_vectors();
        logic [3:0]  gw;
        logic [31:0] got;
        do_store(32'hA000_000C, 32'h80F1_7F22, SZ_WORD, gw);
        do_load(32'hA000_000F, SZ_BYTE, 1'b0, 1'b0, got);
        n_vec++; if (got !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_signed got %h exp ffffff80", got); end
        do_load(32'h0000_000F, SZ_BYTE, 1'b1, 1'b1, got);
        n_vec++; if (got !== 32'h0000_0080) begin n_err++; $display("FAIL lbu got %h exp 00000080", got); end
        do_store(32'h0000_0012, 32'h0000_BEEF, SZ_HALF, gw);
        n_vec++; if (gw !== 4'b1100) begin n_err++; $display("FAIL sh_we got %b exp 1100", gw); end
        do_load(32'h0000_0012, SZ_HALF, 1'b1, 1'b0, got);
        n_vec++; if (got !== 32'h0000_BEEF) begin n_err++; $display("FAIL lhu got %h exp 0000beef", got); end
        do_load(32'h0000_0011, SZ_WORD, 1'b0, 1'b0, got);
        n_vec++; if (got !== 32'h0) begin n_err++; $display("FAIL lw_misaligned got %h exp 0", got); end
        do_store(32'h0000_0022, 32'hCAFE_F00D, SZ_WORD, gw);
        n_vec++; if (gw !== 4'b0000) begin n_err++; $display("FAIL sw_misaligned_we got %b exp 0000", gw); end
    endtask

    task automatic test_random_mem();
        logic [31:0] a, got;
        logic [3:0]  gw;
        logic [1:0]  sz;
        for (int it = 0; it < 60; it++) begin
            a  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_store(a, $urandom, sz, gw);
            else do_load(a, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
        end
    endtask

    task automatic test_io();
        logic [31:0] a, got;
        logic [1:0]  sz;
        logic        rd;
        io_access(1'b1, 32'h8000_0100, SZ_WORD, 1'b0, 32'h0, 5, 32'h1234_5678, got);
        n_vec++; if (got !== 32'h1234_5678) begin n_err++; $display("FAIL io_read_known got %h exp 12345678", got); end
        for (int it = 0; it < 8; it++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom & ~32'd3;
            if (sz == SZ_BYTE) a = a | 32'($urandom_range(0, 3));
            if (sz == SZ_HALF) a = a | (32'($urandom_range(0, 1)) << 1);
            rd = 1'($urandom_range(0, 1));
            io_access(rd, a, sz, 1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 10), $urandom, got);
        end
        bus.io_ready = 1'b1; bus.io_rdata = $urandom;
        tick();
        bus.io_ready = 1'b0;
        n_vec++; if ({valid_o, err_o, bus.io_re} !== 3'b000) begin n_err++; $display("FAIL io_ready_idle got %b exp 000", {valid_o, err_o, bus.io_re}); end
    endtask

    task automatic test_io_timeout();
        logic [31:0] got;
        io_access(1'b1, 32'h8000_0200, SZ_WORD, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, got);
        n_vec++; if (got !== 32'h0) begin n_err++; $display("FAIL io_timeout_data got %h exp 0", got); end
        io_access(1'b1, 32'h8000_0204, SZ_WORD, 1'b0, 32'h0, IO_TIMEOUT, 32'h0BAD_F00D, got);
        n_vec++; if (got !== 32'h0BAD_F00D) begin n_err++; $display("FAIL io_ready_wins got %h exp 0badf00d", got); end
    endtask

    task automatic test_reset_mid_io();
        logic [31:0] got;
        clear_in();
        IoRead_i = 1'b1; ByteOrWord_i = SZ_WORD; ALUResult_i = 32'h8000_0300; LoadUnsigned_i = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        clear_in();
        tick();
        n_vec++; if ({valid_o, stall_o, misalign_o, err_o, bus.io_re, bus.io_we} !== 6'b0) begin n_err++; $display("FAIL rst_mid_flags got %b exp 0", {valid_o, stall_o, misalign_o, err_o, bus.io_re, bus.io_we}); end
        n_vec++; if ({rdata_o, bus.io_addr} !== 64'h0) begin n_err++; $display("FAIL rst_mid_data got %h exp 0", {rdata_o, bus.io_addr}); end
        rst_n = 1'b0;
        tick();
        do_load(32'h0000_0030, SZ_WORD, 1'b0, 1'b0, got);
        n_vec++; if (got !== ref_load(32'h0000_0030, SZ_WORD, 1'b0)) begin n_err++; $display("FAIL rst_mid_lw got %h exp %h", got, ref_load(32'h0000_0030, SZ_WORD, 1'b0)); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got still running exp finished");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_fill();
        test_known_vectors();
        test_random_mem();
        test_io();
        test_io_timeout();
        test_reset_mid_io();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
